cfu_mac_array: RTL and testbench
================================

# cfu_mac_array

Parametrised successor CFU for int8 convolution/FC kernels: 4-lane signed-byte offset dot product feeding a bank of `NUM_ACC` accumulators. Adds indexed and auto-incrementing accumulator targets, read-with-clear, saturating readback and a sticky error/status word. It uses a 2-stage pipeline that sustains one command per cycle. It sits on the CPU custom-function-unit port, driven by the TFLM kernel inner loops.

## Interface
- `NUM_ACC`, 8: accumulator count; 1..256; `IDX_W = max(1, clog2(NUM_ACC))`.
- `ACC_W`, 32: accumulator width; 32..48.
- `clk` in 1: single clock, all state on rising edge.
- `reset` in 1: synchronous, active-high.
- `cmd_valid` in 1: command offered.
- `cmd_ready` out 1: command accepted when `cmd_valid && cmd_ready`.
- `cmd_payload_function_id` in 10: `[9:3]` opcode, `[2:0]` modifier.
- `cmd_payload_inputs_0` in 32: operand A.
- `cmd_payload_inputs_1` in 32: operand B.
- `rsp_valid` out 1: response held until `rsp_ready`.
- `rsp_ready` in 1: response consumed.
- `rsp_payload_outputs_0` out 32: response data.

## Operation
- Stored state:
  - `in_off`, `flt_off`: 16-bit signed, each set from `inputs_0[15:0]`.
  - `gin`: 32-bit global input word.
  - `ptr`: IDX_W-bit auto index.
  - `err`: 1-bit sticky error.
  - `acc[NUM_ACC]`: ACC_W-bit signed accumulators.
- dot(x,f) = Σ over k=0..3 of (sext(x byte k) + in_off) × (sext(f byte k) + flt_off).
  - Each product is 32-bit signed.
  - The sum is sign-extended to ACC_W.
  - Accumulation wraps modulo 2^ACC_W.
- Opcodes (response value in brackets):
  - 0 SET_IN_OFF: sets `in_off` [sext(inputs_0[15:0])].
  - 1 SET_FLT_OFF: sets `flt_off` [same as opcode 0].
  - 2 SET_GIN: `gin`=inputs_0; `ptr`=0 [0].
  - 3 MACC_IDX: acc[inputs_1[IDX_W-1:0]] += dot(gin, inputs_0) [0].
    - If inputs_1 ≥ NUM_ACC: no update, `err`=1.
  - 4 MACC_AUTO: acc[ptr] += dot(gin, inputs_0); `ptr` advances by 1 and wraps NUM_ACC-1 → 0 [ptr before increment].
  - 5 READ_ACC: response is acc[inputs_0]; index out of range gives 0 and sets `err`.
    - Modifier bit0=1: the read accumulator is also cleared.
    - Modifier bit1=1: the value is saturated to int32; otherwise the low 32 bits are returned.
  - 6 CLEAR_ALL: all acc, `ptr` and `err` set to 0 [0].
  - 7 STATUS [{err, 7'b0, 8'(ptr), 16'(NUM_ACC)}].
  - Any other opcode: no state change [0].
- Ordering:
  - Offsets, `gin` and products are resolved at acceptance (stage S1 load).
  - Accumulator updates, `ptr`, reads, clears and `err` are resolved at the S1→S2 transfer.
  - A READ or MACC issued back-to-back after a MACC therefore sees the updated value; there are no hazards.

## Timing
- Pipeline: S1 holds decoded op, index operand and four registered products; S2 is the response register.
- `s2_free = !rsp_valid || rsp_ready`.
- `cmd_ready = !s1_valid || s2_free`.
- S1→S2 transfer occurs when `s1_valid && s2_free`.
- Latency: acceptance in cycle N gives `rsp_valid` in cycle N+2.
- Throughput: 1 command per cycle while `rsp_ready` stays high.
- Backpressure: while `rsp_ready` is low, S2 and S1 hold, and at most 2 commands are in flight.
  - `rsp_payload_outputs_0` stays stable while `rsp_valid && !rsp_ready`.
- Reset values: `rsp_valid`=0, `rsp_payload_outputs_0`=0, `cmd_ready`=1 (next cycle); all state 0.
- Reset mid-operation: in-flight commands are dropped without a response.
- Simultaneous CLEAR_ALL in S2 and MACC accept in S1: the MACC products are unaffected and land on the cleared bank.

## Structure
- Package `cfu_mac_pkg`: opcode constants, modifier bit positions, STATUS field offsets, and `sat32` function.
- Sub-module `cfu_dot4`: combinational 4-lane offset dot product. It is instantiated once and registered into S1 by the parent.

## Test plan
- After reset, STATUS → 0x00000008.
- Offsets in_off=128, flt_off=0; SET_GIN 0x01010101; MACC_IDX inputs_0=0x02020202 idx 3; READ_ACC 3 → 129·2·4 = 1032.
- SET_GIN, then MACC_AUTO ×9 with NUM_ACC=8:
  - Responses are 0..7, 0.
  - acc0 holds two contributions.
  - STATUS ptr=1.
- MACC_IDX idx=8 → err set, no acc changes; STATUS bit31=1; CLEAR_ALL clears it.
- ACC_W=40, accumulate past 2^31:
  - READ with bit1=1 → 0x7FFFFFFF.
  - READ with bit1=0 → low 32 bits.
  - READ with bit0=1, then READ again → 0.
- Back-to-back MACC then READ with `rsp_ready` toggling randomly:
  - Response order and values match the model.
  - No command is lost.
  - `cmd_ready` drops only when both stages are full.

Source files
------------

// File: rtl/cfu_mac_pkg.sv
// Shared opcode/modifier/status definitions for the int8 MAC-array CFU.
// Also holds the int32 saturation helper used on accumulator readback.
package cfu_mac_pkg;

  typedef enum logic [6:0] {
    OP_SET_IN_OFF  = 7'd0,
    OP_SET_FLT_OFF = 7'd1,
    OP_SET_GIN     = 7'd2,
    OP_MACC_IDX    = 7'd3,
    OP_MACC_AUTO   = 7'd4,
    OP_READ_ACC    = 7'd5,
    OP_CLEAR_ALL   = 7'd6,
    OP_STATUS      = 7'd7
  } op_e;

  localparam int MOD_CLR = 0;
  localparam int MOD_SAT = 1;

  localparam int ST_ERR  = 31;
  localparam int ST_PTR  = 16;
  localparam int ST_NACC = 0;

  // Decoded command parked in S1 while its products are registered alongside
  typedef struct packed {
    op_e         op;
    logic [1:0]  mod;
    logic [31:0] a;
    logic [31:0] b;
  } s1_t;

  localparam logic signed [47:0] I32_MAX = 48'sh0000_7FFF_FFFF;
  localparam logic signed [47:0] I32_MIN = -48'sh0000_8000_0000;

  function automatic logic [31:0] sat32(input logic signed [47:0] v);
    if (v > I32_MAX) return 32'h7FFF_FFFF;
    if (v < I32_MIN) return 32'h8000_0000;
    return v[31:0];
  endfunction

endpackage

// File: rtl/cfu_dot4.sv
// Combinational 4-lane offset product: (sext(x byte)+x_off) * (sext(f byte)+f_off).
// Each lane product is truncated to 32 bits; the parent registers and sums them.
module cfu_dot4 (
  input  logic [31:0]       x_i,
  input  logic [31:0]       f_i,
  input  logic [15:0]       x_off_i,
  input  logic [15:0]       f_off_i,
  output logic [3:0][31:0]  prod_o
);

  for (genvar k = 0; k < 4; k++) begin : g_lane
    logic signed [16:0] xa, fa;
    assign xa = 17'(signed'(x_i[8*k +: 8])) + 17'(signed'(x_off_i));
    assign fa = 17'(signed'(f_i[8*k +: 8])) + 17'(signed'(f_off_i));
    assign prod_o[k] = 32'(xa * fa);
  end

endmodule

// File: rtl/cfu_mac_array.sv
// Two-stage CFU: S1 holds decoded op + registered lane products, S2 is the
// response register. Accumulator/ptr/err side effects happen on S1->S2 transfer.
module cfu_mac_array
  import cfu_mac_pkg::*;
#(
  parameter int NUM_ACC = 8,
  parameter int ACC_W   = 32
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        cmd_valid,
  output logic        cmd_ready,
  input  logic [9:0]  cmd_payload_function_id,
  input  logic [31:0] cmd_payload_inputs_0,
  input  logic [31:0] cmd_payload_inputs_1,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [31:0] rsp_payload_outputs_0
);

  localparam int IDX_W = (NUM_ACC > 1) ? $clog2(NUM_ACC) : 1;

  logic                          s1_valid_q, s1_valid_d;
  s1_t                           s1_q, s1_d;
  logic [3:0][31:0]              prod_q, prod_d;
  logic [15:0]                   in_off_q, in_off_d, flt_off_q, flt_off_d;
  logic [31:0]                   gin_q, gin_d;
  logic [IDX_W-1:0]              ptr_q, ptr_d;
  logic                          err_q, err_d;
  logic [NUM_ACC-1:0][ACC_W-1:0] acc_q, acc_d;
  logic                          rsp_valid_q, rsp_valid_d;
  logic [31:0]                   rsp_data_q, rsp_data_d;

  logic s2_free, accept, xfer;
  op_e  in_op;
  logic unused_fid;

  assign s2_free   = !rsp_valid_q || rsp_ready;
  assign cmd_ready = !s1_valid_q || s2_free;
  assign accept    = cmd_valid && cmd_ready;
  assign xfer      = s1_valid_q && s2_free;
  assign in_op     = op_e'(cmd_payload_function_id[9:3]);
  assign unused_fid = cmd_payload_function_id[2];

  assign rsp_valid             = rsp_valid_q;
  assign rsp_payload_outputs_0 = rsp_data_q;

  // Products use the offsets/gin as they stand when the command is accepted
  cfu_dot4 u_dot (
    .x_i     (gin_q),
    .f_i     (cmd_payload_inputs_0),
    .x_off_i (in_off_q),
    .f_off_i (flt_off_q),
    .prod_o  (prod_d)
  );

  logic signed [31:0]      dot_sum;
  logic [ACC_W-1:0]        dot_ext;
  logic                    a_in_rng, b_in_rng;
  logic [IDX_W-1:0]        a_idx, b_idx;
  logic signed [ACC_W-1:0] rd_val;
  logic [31:0]             status;

  assign dot_sum  = prod_q[0] + prod_q[1] + prod_q[2] + prod_q[3];
  assign dot_ext  = ACC_W'(dot_sum);
  assign a_in_rng = s1_q.a < 32'(NUM_ACC);
  assign b_in_rng = s1_q.b < 32'(NUM_ACC);
  assign a_idx    = s1_q.a[IDX_W-1:0];
  assign b_idx    = s1_q.b[IDX_W-1:0];
  assign rd_val   = acc_q[a_idx];

  always_comb begin
    status = '0;
    status[ST_ERR]          = err_q;
    status[ST_PTR +: 8]     = 8'(ptr_q);
    status[ST_NACC +: 16]   = 16'(NUM_ACC);
  end

  always_comb begin
    s1_valid_d = s1_valid_q && !xfer;
    s1_d       = s1_q;
    in_off_d   = in_off_q;
    flt_off_d  = flt_off_q;
    gin_d      = gin_q;
    if (accept) begin
      s1_valid_d = 1'b1;
      s1_d.op    = in_op;
      s1_d.mod   = cmd_payload_function_id[1:0];
      s1_d.a     = cmd_payload_inputs_0;
      s1_d.b     = cmd_payload_inputs_1;
      case (in_op)
        OP_SET_IN_OFF:  in_off_d  = cmd_payload_inputs_0[15:0];
        OP_SET_FLT_OFF: flt_off_d = cmd_payload_inputs_0[15:0];
        OP_SET_GIN:     gin_d     = cmd_payload_inputs_0;
        default: ;
      endcase
    end
  end

  always_comb begin
    acc_d       = acc_q;
    ptr_d       = ptr_q;
    err_d       = err_q;
    rsp_valid_d = rsp_valid_q && !rsp_ready;
    rsp_data_d  = rsp_data_q;
    if (xfer) begin
      rsp_valid_d = 1'b1;
      rsp_data_d  = '0;
      case (s1_q.op)
        OP_SET_IN_OFF, OP_SET_FLT_OFF: rsp_data_d = 32'(signed'(s1_q.a[15:0]));
        OP_SET_GIN: ptr_d = '0;
        OP_MACC_IDX: begin
          if (b_in_rng) acc_d[b_idx] = acc_q[b_idx] + dot_ext;
          else          err_d = 1'b1;
        end
        OP_MACC_AUTO: begin
          acc_d[ptr_q] = acc_q[ptr_q] + dot_ext;
          rsp_data_d   = 32'(ptr_q);
          ptr_d        = (ptr_q == IDX_W'(NUM_ACC - 1)) ? '0 : ptr_q + IDX_W'(1);
        end
        OP_READ_ACC: begin
          if (a_in_rng) begin
            rsp_data_d = s1_q.mod[MOD_SAT] ? sat32(48'(rd_val)) : rd_val[31:0];
            if (s1_q.mod[MOD_CLR]) acc_d[a_idx] = '0;
          end else begin
            err_d = 1'b1;
          end
        end
        OP_CLEAR_ALL: begin
          acc_d = '0;
          ptr_d = '0;
          err_d = 1'b0;
        end
        OP_STATUS: rsp_data_d = status;
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      s1_valid_q  <= 1'b0;
      s1_q        <= '0;
      prod_q      <= '0;
      in_off_q    <= '0;
      flt_off_q   <= '0;
      gin_q       <= '0;
      ptr_q       <= '0;
      err_q       <= 1'b0;
      acc_q       <= '0;
      rsp_valid_q <= 1'b0;
      rsp_data_q  <= '0;
    end else begin
      s1_valid_q  <= s1_valid_d;
      s1_q        <= s1_d;
      if (accept) prod_q <= prod_d;
      in_off_q    <= in_off_d;
      flt_off_q   <= flt_off_d;
      gin_q       <= gin_d;
      ptr_q       <= ptr_d;
      err_q       <= err_d;
      acc_q       <= acc_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_data_q  <= rsp_data_d;
    end
  end

endmodule

// File: tb/tb_cfu_mac_array.sv
// Directed bench for cfu_mac_array (NUM_ACC=8, ACC_W=40): command table with
// hand-computed responses, then backpressure streaming and reset-while-busy.
module tb_cfu_mac_array;

  localparam logic [6:0] SIN = 7'd0, SFL = 7'd1, GIN = 7'd2, MIDX = 7'd3,
                         MAUTO = 7'd4, RD = 7'd5, CLR = 7'd6, ST = 7'd7;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        cmd_valid = 1'b0;
  logic        cmd_ready;
  logic [9:0]  cmd_payload_function_id = '0;
  logic [31:0] cmd_payload_inputs_0 = '0;
  logic [31:0] cmd_payload_inputs_1 = '0;
  logic        rsp_valid;
  logic        rsp_ready = 1'b1;
  logic [31:0] rsp_payload_outputs_0;

  cfu_mac_array #(.NUM_ACC(8), .ACC_W(40)) dut (
    .clk                     (clk),
    .reset                   (reset),
    .cmd_valid               (cmd_valid),
    .cmd_ready               (cmd_ready),
    .cmd_payload_function_id (cmd_payload_function_id),
    .cmd_payload_inputs_0    (cmd_payload_inputs_0),
    .cmd_payload_inputs_1    (cmd_payload_inputs_1),
    .rsp_valid               (rsp_valid),
    .rsp_ready               (rsp_ready),
    .rsp_payload_outputs_0   (rsp_payload_outputs_0)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [6:0]  op;
    logic [2:0]  md;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] exp;
  } vec_t;

  vec_t        vq[$];
  vec_t        sq[$];
  int          tests = 0;
  int          fails = 0;
  logic [31:0] r;
  bit          ok;
  int          sent, got, infl, cyc, rule_bad, hold_bad;
  bit          hold, seen, acc_now, con_now;
  logic [31:0] hold_d, run_sum;

  function automatic void add(input logic [6:0] op, input logic [2:0] md,
                              input logic [31:0] a, input logic [31:0] b,
                              input logic [31:0] exp);
    vq.push_back('{op, md, a, b, exp});
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  // One command with rsp_ready held high; ok=0 if either handshake times out
  task automatic do_cmd(input logic [6:0] op, input logic [2:0] md,
                        input logic [31:0] a, input logic [31:0] b,
                        output logic [31:0] rv, output bit okv);
    int n;
    okv = 1'b1;
    rv  = '0;
    @(negedge clk);
    rsp_ready = 1'b1;
    cmd_valid = 1'b1;
    cmd_payload_function_id = {op, md};
    cmd_payload_inputs_0 = a;
    cmd_payload_inputs_1 = b;
    n = 0;
    while (!cmd_ready && n < 20) begin @(negedge clk); n++; end
    @(posedge clk); #1;
    cmd_valid = 1'b0;
    n = 0;
    while (!rsp_valid && n < 20) begin @(negedge clk); n++; end
    if (!rsp_valid) okv = 1'b0;
    else rv = rsp_payload_outputs_0;
  endtask

  task automatic run(input string nm, input logic [6:0] op, input logic [2:0] md,
                     input logic [31:0] a, input logic [31:0] b, input logic [31:0] exp);
    logic [31:0] rv;
    bit okv;
    do_cmd(op, md, a, b, rv, okv);
    if (!okv) begin
      tests++;
      fails++;
      $display("FAIL %s: no response within bound, expected %h", nm, exp);
    end else begin
      chk(nm, rv, exp);
    end
  endtask

  initial begin
    #300000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_rsp_valid", {31'd0, rsp_valid}, 32'd0);
    chk("rst_rsp_data", rsp_payload_outputs_0, 32'd0);
    chk("rst_cmd_ready", {31'd0, cmd_ready}, 32'd1);
    reset = 1'b0;

    add(ST, 0, 0, 0, 32'h0000_0008);
    add(SIN, 0, 128, 0, 128);
    add(SFL, 0, 0, 0, 0);
    add(GIN, 0, 32'h0101_0101, 0, 0);
    add(MIDX, 0, 32'h0202_0202, 3, 0);
    add(RD, 0, 3, 0, 1032);
    add(SFL, 0, 32'hABCD_FFFF, 0, 32'hFFFF_FFFF);
    add(MIDX, 0, 32'h0303_0303, 3, 0);
    add(RD, 1, 3, 0, 2064);
    add(RD, 0, 3, 0, 0);
    add(SIN, 0, 32'h0000_FF80, 0, 32'hFFFF_FF80);
    add(MIDX, 0, 32'hFFFE_FD05, 0, 0);
    add(RD, 0, 0, 0, 635);
    add(SIN, 0, 0, 0, 0);
    add(MIDX, 0, 0, 0, 0);
    add(RD, 1, 0, 0, 631);
    add(7'd9, 0, 32'h1234_5678, 0, 0);
    add(ST, 0, 0, 0, 32'h0000_0008);
    add(SFL, 0, 0, 0, 0);
    add(CLR, 0, 0, 0, 0);
    add(GIN, 0, 32'h0101_0101, 0, 0);
    for (int k = 0; k < 9; k++) add(MAUTO, 0, 32'h0101_0101, 0, 32'(k % 8));
    add(RD, 0, 0, 0, 8);
    add(RD, 0, 1, 0, 4);
    add(RD, 0, 7, 0, 4);
    add(ST, 0, 0, 0, 32'h0001_0008);
    add(MIDX, 0, 32'h0101_0101, 8, 0);
    add(RD, 0, 0, 0, 8);
    add(ST, 0, 0, 0, 32'h8001_0008);
    add(GIN, 0, 32'h0101_0101, 0, 0);
    add(ST, 0, 0, 0, 32'h8000_0008);
    add(RD, 0, 9, 0, 0);
    add(CLR, 0, 0, 0, 0);
    add(ST, 0, 0, 0, 32'h0000_0008);
    add(RD, 0, 0, 0, 0);
    add(MIDX, 0, 32'h0101_0101, 32'h0000_0100, 0);
    add(ST, 0, 0, 0, 32'h8000_0008);
    add(RD, 0, 0, 0, 0);
    add(CLR, 0, 0, 0, 0);
    add(ST, 0, 0, 0, 32'h0000_0008);
    add(SIN, 0, 32'h4000, 0, 32'h4000);
    add(SFL, 0, 32'h4000, 0, 32'h4000);
    add(GIN, 0, 0, 0, 0);
    for (int k = 0; k < 3; k++) add(MIDX, 0, 0, 5, 0);
    add(RD, 2, 5, 0, 32'h7FFF_FFFF);
    add(RD, 0, 5, 0, 32'hC000_0000);
    add(RD, 1, 5, 0, 32'hC000_0000);
    add(RD, 0, 5, 0, 0);
    add(SFL, 0, 32'hC000, 0, 32'hFFFF_C000);
    for (int k = 0; k < 3; k++) add(MIDX, 0, 0, 6, 0);
    add(RD, 2, 6, 0, 32'h8000_0000);
    add(RD, 0, 6, 0, 32'h4000_0000);
    add(RD, 3, 6, 0, 32'h8000_0000);
    add(RD, 0, 6, 0, 0);

    foreach (vq[i])
      run($sformatf("vec%0d_op%0d", i, vq[i].op), vq[i].op, vq[i].md, vq[i].a, vq[i].b, vq[i].exp);

    // Streaming MACC/READ pairs against random response backpressure
    run("stream_sin", SIN, 0, 0, 0, 0);
    run("stream_sfl", SFL, 0, 0, 0, 0);
    run("stream_gin", GIN, 0, 32'h0101_0101, 0, 0);
    run("stream_clr", CLR, 0, 0, 0, 0);
    run_sum = 0;
    for (int k = 1; k <= 6; k++) begin
      run_sum += 32'(4 * k);
      sq.push_back('{MIDX, 3'd0, {4{8'(k)}}, 32'd2, 32'd0});
      sq.push_back('{RD, 3'd0, 32'd2, 32'd0, run_sum});
    end
    sent = 0; got = 0; infl = 0; cyc = 0; rule_bad = 0; hold_bad = 0; hold = 0; hold_d = '0;
    @(negedge clk);
    while (got < sq.size() && cyc < 2000) begin
      rsp_ready = ($urandom_range(0, 2) != 0);
      if (sent < sq.size()) begin
        cmd_valid = 1'b1;
        cmd_payload_function_id = {sq[sent].op, sq[sent].md};
        cmd_payload_inputs_0 = sq[sent].a;
        cmd_payload_inputs_1 = sq[sent].b;
      end else begin
        cmd_valid = 1'b0;
      end
      #1;
      if (cmd_ready !== !(infl == 2 && !rsp_ready)) rule_bad++;
      if (hold && (!rsp_valid || rsp_payload_outputs_0 !== hold_d)) hold_bad++;
      con_now = rsp_valid && rsp_ready;
      acc_now = cmd_valid && cmd_ready;
      if (con_now) begin
        chk($sformatf("stream_rsp%0d", got), rsp_payload_outputs_0, sq[got].exp);
        got++;
      end
      hold   = rsp_valid && !rsp_ready;
      hold_d = rsp_payload_outputs_0;
      if (acc_now) sent++;
      infl = infl + int'(acc_now) - int'(con_now);
      cyc++;
      @(negedge clk);
    end
    cmd_valid = 1'b0;
    rsp_ready = 1'b1;
    chk("stream_count", 32'(got), 32'(sq.size()));
    chk("stream_cmd_ready_rule", 32'(rule_bad), 0);
    chk("stream_rsp_stable", 32'(hold_bad), 0);

    // Reset while a MACC sits in S1: it must vanish without a response
    run("mid_sin", SIN, 0, 16, 0, 16);
    @(negedge clk);
    cmd_valid = 1'b1;
    cmd_payload_function_id = {MIDX, 3'd0};
    cmd_payload_inputs_0 = 32'h0101_0101;
    cmd_payload_inputs_1 = 1;
    @(posedge clk); #1;
    cmd_valid = 1'b0;
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    seen = rsp_valid;
    repeat (3) begin @(negedge clk); seen |= rsp_valid; end
    chk("mid_rst_no_rsp", {31'd0, seen}, 32'd0);
    run("mid_rst_acc1", RD, 0, 1, 0, 0);
    run("mid_rst_status", ST, 0, 0, 0, 32'h0000_0008);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
